reg_ctx_engine: RTL and testbench

Context save/restore engine for the MicroUAZ8 core. It is the master side of the 8x8 register bank port: it drives SelR/RW/DW and samples Rx.
- On command, it copies a masked subset of R0..R7 into a contiguous data-memory block (SAVE), or reloads them from that block (RESTORE).
- Used by interrupt entry/exit and CALL/RET microcode. The core is stalled while Busy=1.

---
 rtl/reg_ctx_engine.sv | 132 +++++++++++++
 tb/tb_reg_ctx_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctx_engine.sv
`default_nettype none
// ============================================================================
// Module      : reg_ctx_engine
// Description : Context save/restore engine for the MicroUAZ8 core. Copies a
//               masked subset of the register bank to a packed data-memory
//               block (SAVE) or reloads it from that block (RESTORE).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_ctx_engine #(
  parameter int NREG = 8,
  parameter int DW   = 8,
  parameter int AW   = 8
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic            Op,
  input  logic [AW-1:0]   Base,
  input  logic [NREG-1:0] Mask,
  output logic            Busy,
  output logic            Done,
  output logic [5:0]      SelR,
  output logic            RW,
  output logic [DW-1:0]   DWo,
  input  logic [DW-1:0]   Rx,
  output logic [AW-1:0]   Mem_Addr,
  output logic            Mem_WE,
  output logic [DW-1:0]   Mem_DO,
  input  logic [DW-1:0]   Mem_DI
);

  localparam int c_IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAVE   = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_WR  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [NREG-1:0]     r_pending;
  logic [NREG-1:0]     w_pending_nxt;
  logic [NREG-1:0]     w_cleared;
  logic [AW-1:0]       r_ptr;
  logic [AW-1:0]       w_ptr_nxt;
  logic [c_IDX_W-1:0]  w_idx;

  // Lowest set bit of the pending mask picks the register handled this cycle;
  // scanning downwards lets the lowest index overwrite higher ones.
  always_comb begin
    w_idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_pending[i]) w_idx = c_IDX_W'(i);
    end
  end

  assign w_cleared = r_pending & ~(NREG'(1) << w_idx);

  // State, pending mask and memory pointer; reset aborts any command at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_next;
      r_pending <= w_pending_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  // Next-state and Moore outputs; every output idles at its reset value.
  always_comb begin
    w_next        = r_state;
    w_pending_nxt = r_pending;
    w_ptr_nxt     = r_ptr;
    Busy          = 1'b0;
    Done          = 1'b0;
    SelR          = '0;
    RW            = 1'b0;
    DWo           = '0;
    Mem_Addr      = '0;
    Mem_WE        = 1'b0;
    Mem_DO        = '0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_pending_nxt = Mask;
          w_ptr_nxt     = Base;
          if (Mask == '0) w_next = S_DONE;
          else            w_next = Op ? S_RD_REQ : S_SAVE;
        end
      end
      S_SAVE: begin
        Busy          = 1'b1;
        SelR          = 6'(w_idx);
        Mem_Addr      = r_ptr;
        Mem_DO        = Rx;
        Mem_WE        = 1'b1;
        w_pending_nxt = w_cleared;
        w_ptr_nxt     = r_ptr + AW'(1);
        if (w_cleared == '0) w_next = S_DONE;
      end
      S_RD_REQ: begin
        // Present the address; synchronous memory returns data next cycle.
        Busy     = 1'b1;
        Mem_Addr = r_ptr;
        w_next   = S_RD_WR;
      end
      S_RD_WR: begin
        Busy          = 1'b1;
        SelR          = 6'(w_idx);
        DWo           = Mem_DI;
        RW            = 1'b1;
        w_pending_nxt = w_cleared;
        w_ptr_nxt     = r_ptr + AW'(1);
        w_next        = (w_cleared != '0) ? S_RD_REQ : S_DONE;
      end
      S_DONE: begin
        Busy   = 1'b1;
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_ctx_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_ctx_engine
// Description : Directed self-checking bench for reg_ctx_engine with a
//               behavioural 8x8 register bank and synchronous data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_ctx_engine;

  logic       Clk = 1'b0;
  logic       Rst, Start, Op;
  logic [7:0] Base, Mask;
  logic       Busy, Done, RW, Mem_WE;
  logic [5:0] SelR;
  logic [7:0] DWo, Rx, Mem_Addr, Mem_DO, Mem_DI;

  logic [7:0] rgs [8];
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  reg_ctx_engine #(.NREG(8), .DW(8), .AW(8)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .Base(Base), .Mask(Mask),
    .Busy(Busy), .Done(Done), .SelR(SelR), .RW(RW), .DWo(DWo), .Rx(Rx),
    .Mem_Addr(Mem_Addr), .Mem_WE(Mem_WE), .Mem_DO(Mem_DO), .Mem_DI(Mem_DI)
  );

  always #5 Clk = ~Clk;

  assign Rx = rgs[SelR[2:0]];

  // Bank write port and synchronous memory
  always @(posedge Clk) begin
    if (RW) rgs[SelR[2:0]] <= DWo;
    if (Mem_WE) mem[Mem_Addr] <= Mem_DO;
    Mem_DI <= mem[Mem_Addr];
  end

  // Issue one command and observe it until Done (bounded at 40 cycles).
  task automatic run_cmd(input logic op, input logic [7:0] base, input logic [7:0] mask,
                         output int dcyc, output int wcnt, output int rcnt,
                         output int both, output int nbusy);
    @(negedge Clk);
    Start = 1'b1; Op = op; Base = base; Mask = mask;
    @(posedge Clk); #1;
    Start = 1'b0;
    dcyc = -1; wcnt = 0; rcnt = 0; both = 0; nbusy = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (Mem_WE) wcnt++;
      if (RW) rcnt++;
      if (RW && Mem_WE) both++;
      if (!Busy) nbusy++;
      if (Done) begin dcyc = c; break; end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", Done); end
    checks++; if ({RW, Mem_WE} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b expected 00", {RW, Mem_WE}); end
    checks++; if ({SelR, DWo, Mem_Addr, Mem_DO} !== 30'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {SelR, DWo, Mem_Addr, Mem_DO}); end
    @(negedge Clk); Rst = 1'b0;
  endtask

  task automatic test_save_all();
    int d, w, r, b, nb;
    for (int i = 0; i < 8; i++) rgs[i] = 8'h10 + 8'(i);
    run_cmd(1'b0, 8'h40, 8'hFF, d, w, r, b, nb);
    checks++; if (d !== 9) begin errors++; $display("FAIL save_all_done_cycle: got %0d expected 9", d); end
    checks++; if (w !== 8) begin errors++; $display("FAIL save_all_we_count: got %0d expected 8", w); end
    checks++; if (r !== 0) begin errors++; $display("FAIL save_all_rw_count: got %0d expected 0", r); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL save_all_busy_gap: got %0d expected 0", nb); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mem[8'h40 + i] !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL save_all_mem[%0d]: got %h expected %h", i, mem[8'h40 + i], 8'h10 + 8'(i));
      end
    end
  endtask

  task automatic test_save_sparse();
    int d, w, r, b, nb;
    mem[8'h83] = 8'h5A;
    run_cmd(1'b0, 8'h80, 8'b1010_0100, d, w, r, b, nb);
    checks++; if (d !== 4) begin errors++; $display("FAIL sparse_done_cycle: got %0d expected 4", d); end
    checks++; if (w !== 3) begin errors++; $display("FAIL sparse_we_count: got %0d expected 3", w); end
    checks++; if (mem[8'h80] !== 8'h12) begin errors++; $display("FAIL sparse_mem80: got %h expected 12", mem[8'h80]); end
    checks++; if (mem[8'h81] !== 8'h15) begin errors++; $display("FAIL sparse_mem81: got %h expected 15", mem[8'h81]); end
    checks++; if (mem[8'h82] !== 8'h17) begin errors++; $display("FAIL sparse_mem82: got %h expected 17", mem[8'h82]); end
    checks++; if (mem[8'h83] !== 8'h5A) begin errors++; $display("FAIL sparse_mem83: got %h expected 5a", mem[8'h83]); end
  endtask

  task automatic test_restore();
    int d, w, r, b, nb;
    logic [7:0] exp_r [8];
    exp_r = '{8'hA1, 8'hB2, 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00};
    mem[8'h20] = 8'hA1; mem[8'h21] = 8'hB2; mem[8'h22] = 8'hC3; mem[8'h23] = 8'h99;
    for (int i = 0; i < 8; i++) rgs[i] = 8'h00;
    run_cmd(1'b1, 8'h20, 8'h0B, d, w, r, b, nb);
    checks++; if (d !== 7) begin errors++; $display("FAIL restore_done_cycle: got %0d expected 7", d); end
    checks++; if (w !== 0) begin errors++; $display("FAIL restore_we_count: got %0d expected 0", w); end
    checks++; if (r !== 3) begin errors++; $display("FAIL restore_rw_count: got %0d expected 3", r); end
    checks++; if (b !== 0) begin errors++; $display("FAIL restore_rw_we_overlap: got %0d expected 0", b); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rgs[i] !== exp_r[i]) begin
        errors++; $display("FAIL restore_R%0d: got %h expected %h", i, rgs[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_wrap_and_empty();
    int d, w, r, b, nb;
    for (int i = 0; i < 8; i++) rgs[i] = 8'h10 + 8'(i);
    mem[8'h00] = 8'hEE; mem[8'h01] = 8'hEE;
    run_cmd(1'b0, 8'hFE, 8'h07, d, w, r, b, nb);
    checks++; if (d !== 4) begin errors++; $display("FAIL wrap_done_cycle: got %0d expected 4", d); end
    checks++; if (mem[8'hFE] !== 8'h10) begin errors++; $display("FAIL wrap_memFE: got %h expected 10", mem[8'hFE]); end
    checks++; if (mem[8'hFF] !== 8'h11) begin errors++; $display("FAIL wrap_memFF: got %h expected 11", mem[8'hFF]); end
    checks++; if (mem[8'h00] !== 8'h12) begin errors++; $display("FAIL wrap_mem00: got %h expected 12", mem[8'h00]); end
    checks++; if (mem[8'h01] !== 8'hEE) begin errors++; $display("FAIL wrap_mem01: got %h expected ee", mem[8'h01]); end
    run_cmd(1'b0, 8'h33, 8'h00, d, w, r, b, nb);
    checks++; if (d !== 1) begin errors++; $display("FAIL empty_done_cycle: got %0d expected 1", d); end
    checks++; if (w + r !== 0) begin errors++; $display("FAIL empty_writes: got %0d expected 0", w + r); end
  endtask

  task automatic test_back_to_back();
    int d, w, r, b, nb;
    mem[8'h52] = 8'h77; mem[8'h60] = 8'h66;
    @(negedge Clk);
    Start = 1'b1; Op = 1'b0; Base = 8'h50; Mask = 8'h03;
    @(posedge Clk); #1;
    // Keep Start high with a different command while the first one runs
    Op = 1'b1; Base = 8'h60; Mask = 8'hFF;
    d = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (c == 3) Start = 1'b0;
      if (Done) begin d = c; break; end
    end
    Start = 1'b0;
    checks++; if (d !== 3) begin errors++; $display("FAIL ignore_done_cycle: got %0d expected 3", d); end
    checks++; if (mem[8'h50] !== 8'h10) begin errors++; $display("FAIL ignore_mem50: got %h expected 10", mem[8'h50]); end
    checks++; if (mem[8'h51] !== 8'h11) begin errors++; $display("FAIL ignore_mem51: got %h expected 11", mem[8'h51]); end
    checks++; if (mem[8'h52] !== 8'h77) begin errors++; $display("FAIL ignore_mem52: got %h expected 77", mem[8'h52]); end
    checks++; if (mem[8'h60] !== 8'h66) begin errors++; $display("FAIL ignore_mem60: got %h expected 66", mem[8'h60]); end
    checks++; if (rgs[0] !== 8'h10) begin errors++; $display("FAIL ignore_R0: got %h expected 10", rgs[0]); end
    // Start in the single idle cycle right after Done
    run_cmd(1'b0, 8'h70, 8'h80, d, w, r, b, nb);
    checks++; if (d !== 2) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 2", d); end
    checks++; if (mem[8'h70] !== 8'h17) begin errors++; $display("FAIL b2b_mem70: got %h expected 17", mem[8'h70]); end
  endtask

  task automatic test_reset_mid();
    int d, w, r, b, nb;
    for (int i = 0; i < 8; i++) begin
      mem[8'h30 + i] = 8'hE0 + 8'(i);
      rgs[i] = 8'h10 + 8'(i);
    end
    @(negedge Clk);
    Start = 1'b1; Op = 1'b1; Base = 8'h30; Mask = 8'hFF;
    @(posedge Clk); #1; Start = 1'b0;   // cycle 1: RD_REQ R0
    @(posedge Clk); #1;                 // cycle 2: RD_WR R0
    @(posedge Clk); #1;                 // cycle 3: RD_REQ R1
    @(posedge Clk); #1;                 // cycle 4: RD_WR R1
    checks++; if (RW !== 1'b1) begin errors++; $display("FAIL mid_rw_before_reset: got %b expected 1", RW); end
    Rst = 1'b1;
    #1;
    checks++; if ({Busy, Done, RW, Mem_WE} !== 4'b0000) begin errors++; $display("FAIL mid_ctrl_after_reset: got %b expected 0000", {Busy, Done, RW, Mem_WE}); end
    checks++; if ({SelR, DWo, Mem_Addr, Mem_DO} !== 30'd0) begin errors++; $display("FAIL mid_data_after_reset: got %h expected 0", {SelR, DWo, Mem_Addr, Mem_DO}); end
    @(posedge Clk);
    @(negedge Clk); Rst = 1'b0;
    checks++; if (rgs[0] !== 8'hE0) begin errors++; $display("FAIL mid_R0: got %h expected e0", rgs[0]); end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (rgs[i] !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL mid_R%0d: got %h expected %h", i, rgs[i], 8'h10 + 8'(i));
      end
    end
    run_cmd(1'b0, 8'h90, 8'h01, d, w, r, b, nb);
    checks++; if (d !== 2) begin errors++; $display("FAIL post_reset_done_cycle: got %0d expected 2", d); end
    checks++; if (mem[8'h90] !== 8'hE0) begin errors++; $display("FAIL post_reset_mem90: got %h expected e0", mem[8'h90]); end
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; Op = 1'b0; Base = 8'h00; Mask = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) rgs[i] = 8'h00;
    test_reset();
    test_save_all();
    test_save_sparse();
    test_restore();
    test_wrap_and_empty();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
